// File: rtl/kb_defs_pkg.sv
// Scan-code set-2 constants, prefix-tracking FSM states and the queued entry layout
// shared by the keyboard scan decoder and its bench.
// Pure definitions: no logic, no latency, no flow control.
package kb_defs;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;
    localparam logic [7:0] SC_BAT    = 8'hAA;
    localparam logic [7:0] SC_ACK    = 8'hFA;
    localparam logic [7:0] SC_RESEND = 8'hFE;
    localparam logic [7:0] SC_ECHO   = 8'hEE;

    // Only these two extended makes are forwarded (keypad Enter and keypad '/').
    localparam logic [7:0] SC_KP_ENTER = 8'h5A;
    localparam logic [7:0] SC_KP_SLASH = 8'h4A;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BRK  = 2'd1,
        ST_EXT  = 2'd2,
        ST_EBRK = 2'd3
    } kb_state_e;

    typedef struct packed {
        logic [7:0] code;
        logic       shift;
        logic       caps;
    } kb_entry_t;

endpackage

// File: rtl/kb_fifo.sv
// Synchronous show-ahead FIFO, depth 2^W, head word visible on r_data while not empty.
// Latency: a write is visible at the head the cycle after the write edge.
// Backpressure: writes while full are ignored unless a pop happens in the same cycle.
module kb_fifo #(
    parameter int DW = 10,
    parameter int W  = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr,
    input  logic          rd,
    input  logic [DW-1:0] w_data,
    output logic [DW-1:0] r_data,
    output logic          full,
    output logic          empty
);

    localparam int DEPTH = 1 << W;

    logic [W:0]    wr_ptr_q, wr_ptr_d;
    logic [W:0]    rd_ptr_q, rd_ptr_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic          wr_en, rd_en;

    // Extra pointer bit distinguishes full from empty when the low bits match.
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[W] != rd_ptr_q[W]) && (wr_ptr_q[W-1:0] == rd_ptr_q[W-1:0]);
    assign rd_en  = rd & ~empty;
    assign wr_en  = wr & (~full | rd_en);
    assign r_data = mem_q[rd_ptr_q[W-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + (W+1)'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + (W+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[W-1:0]] <= w_data;
    end

endmodule

// File: rtl/kb_scan_decoder.sv
// Strips F0/E0 prefixes from set-2 scan bytes, tracks shift/caps, queues makes with modifiers.
// Latency: a make byte is at the queue head the cycle after its rx_done_tick.
// Backpressure: none upstream; makes arriving while the queue is full are dropped and flagged.
module kb_scan_decoder
    import kb_defs::*;
#(
    parameter int W = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_data,
    input  logic       rd,
    output logic [7:0] kb_code,
    output logic       shift,
    output logic       caps_lock,
    output logic       kb_empty,
    output logic       caps_led,
    output logic       overflow
);

    kb_state_e state_q, state_d;
    logic      shl_q, shl_d;
    logic      shr_q, shr_d;
    logic      caps_q, caps_d;
    logic      caps_held_q, caps_held_d;
    logic      overflow_q, overflow_d;

    logic      push;
    kb_entry_t push_dat;
    kb_entry_t head;
    logic      fifo_full, fifo_empty;

    always_comb begin
        state_d     = state_q;
        shl_d       = shl_q;
        shr_d       = shr_q;
        caps_d      = caps_q;
        caps_held_d = caps_held_q;
        push        = 1'b0;
        // Snapshot is taken from the modifiers as they stood before this byte.
        push_dat    = '{code: rx_data, shift: shl_q | shr_q, caps: caps_q};

        if (rx_done_tick) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (rx_data == SC_BREAK) begin
                        state_d = ST_BRK;
                    end else if (rx_data == SC_EXT) begin
                        state_d = ST_EXT;
                    end else if (rx_data == SC_BAT || rx_data == SC_ACK ||
                                 rx_data == SC_RESEND || rx_data == SC_ECHO) begin
                        state_d = ST_IDLE;
                    end else if (rx_data == SC_LSHIFT) begin
                        shl_d = 1'b1;
                    end else if (rx_data == SC_RSHIFT) begin
                        shr_d = 1'b1;
                    end else if (rx_data == SC_CAPS) begin
                        // Holding caps produces typematic repeats; only the first one toggles.
                        if (!caps_held_q) begin
                            caps_d      = ~caps_q;
                            caps_held_d = 1'b1;
                        end
                    end else begin
                        push = 1'b1;
                    end
                end
                ST_BRK: begin
                    if (rx_data == SC_LSHIFT) shl_d = 1'b0;
                    if (rx_data == SC_RSHIFT) shr_d = 1'b0;
                    if (rx_data == SC_CAPS)   caps_held_d = 1'b0;
                    state_d = ST_IDLE;
                end
                ST_EXT: begin
                    if (rx_data == SC_BREAK) begin
                        state_d = ST_EBRK;
                    end else begin
                        push    = (rx_data == SC_KP_ENTER) || (rx_data == SC_KP_SLASH);
                        state_d = ST_IDLE;
                    end
                end
                ST_EBRK: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end

        overflow_d = overflow_q | (push & fifo_full & ~(rd & ~fifo_empty));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            shl_q       <= 1'b0;
            shr_q       <= 1'b0;
            caps_q      <= 1'b0;
            caps_held_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shl_q       <= shl_d;
            shr_q       <= shr_d;
            caps_q      <= caps_d;
            caps_held_q <= caps_held_d;
            overflow_q  <= overflow_d;
        end
    end

    kb_fifo #(
        .DW ($bits(kb_entry_t)),
        .W  (W)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr     (push),
        .rd     (rd),
        .w_data (push_dat),
        .r_data (head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign kb_empty  = fifo_empty;
    assign kb_code   = fifo_empty ? 8'h00 : head.code;
    assign shift     = fifo_empty ? 1'b0  : head.shift;
    assign caps_lock = fifo_empty ? 1'b0  : head.caps;
    assign caps_led  = caps_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_kb_scan_decoder.sv
// Bench for kb_scan_decoder: directed scan-code sequences plus random traffic,
// every cycle compared against a prefix/modifier/queue reference model.
module tb_kb_scan_decoder;

    localparam int W     = 2;
    localparam int DEPTH = 1 << W;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_done_tick;
    logic [7:0] rx_data;
    logic       rd;
    logic [7:0] kb_code;
    logic       shift;
    logic       caps_lock;
    logic       kb_empty;
    logic       caps_led;
    logic       overflow;

    int total = 0;
    int bad   = 0;

    kb_scan_decoder #(.W(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_done_tick (rx_done_tick),
        .rx_data      (rx_data),
        .rd           (rd),
        .kb_code      (kb_code),
        .shift        (shift),
        .caps_lock    (caps_lock),
        .kb_empty     (kb_empty),
        .caps_led     (caps_led),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    // Reference model: pending-prefix flags, modifier bits, queue of 10-bit entries.
    bit       m_brk, m_ext, m_ebrk;
    bit       m_shl, m_shr, m_caps, m_held, m_ovf;
    bit [9:0] m_q[$];

    task automatic model_reset();
        m_brk = 0; m_ext = 0; m_ebrk = 0;
        m_shl = 0; m_shr = 0; m_caps = 0; m_held = 0; m_ovf = 0;
        m_q.delete();
    endtask

    // Applies one clock edge: decides push from the pre-edge state, then pops and pushes.
    task automatic model_edge(input bit tick, input bit [7:0] b, input bit pop);
        bit       do_push;
        bit [9:0] ent;
        bit       pop_ok;
        do_push = 0;
        ent     = {b, m_shl | m_shr, m_caps};
        pop_ok  = pop && (m_q.size() > 0);
        if (tick) begin
            if (m_brk) begin
                m_brk = 0;
                if (b == 8'h12) m_shl = 0;
                if (b == 8'h59) m_shr = 0;
                if (b == 8'h58) m_held = 0;
            end else if (m_ebrk) begin
                m_ebrk = 0;
            end else if (m_ext) begin
                m_ext = 0;
                if (b == 8'hF0) m_ebrk = 1;
                else if (b == 8'h5A || b == 8'h4A) do_push = 1;
            end else if (b == 8'hF0) begin
                m_brk = 1;
            end else if (b == 8'hE0) begin
                m_ext = 1;
            end else if (b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE}) begin
                do_push = 0;
            end else if (b == 8'h12) begin
                m_shl = 1;
            end else if (b == 8'h59) begin
                m_shr = 1;
            end else if (b == 8'h58) begin
                if (!m_held) begin
                    m_caps = !m_caps;
                    m_held = 1;
                end
            end else begin
                do_push = 1;
            end
        end
        if (do_push && m_q.size() == DEPTH && !pop_ok) begin
            m_ovf   = 1;
            do_push = 0;
        end
        if (pop_ok) void'(m_q.pop_front());
        if (do_push) m_q.push_back(ent);
    endtask

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        bit [9:0] h;
        bit       e;
        e = (m_q.size() == 0);
        h = e ? 10'h000 : m_q[0];
        chk_eq("kb_empty",  32'(kb_empty),  32'(e));
        chk_eq("kb_code",   32'(kb_code),   32'(h[9:2]));
        chk_eq("shift",     32'(shift),     32'(h[1]));
        chk_eq("caps_lock", 32'(caps_lock), 32'(h[0]));
        chk_eq("caps_led",  32'(caps_led),  32'(m_caps));
        chk_eq("overflow",  32'(overflow),  32'(m_ovf));
    endtask

    // One clock with the given inputs; outputs checked 1 time unit after the edge.
    task automatic step(input bit rst, input bit tick, input bit [7:0] b, input bit pop);
        reset        = rst;
        rx_done_tick = tick;
        rx_data      = b;
        rd           = pop;
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge(tick, b, pop);
        #1;
        check_outputs();
        reset        = 1'b0;
        rx_done_tick = 1'b0;
        rd           = 1'b0;
    endtask

    task automatic send(input bit [7:0] b);
        step(0, 1, b, 0);
    endtask

    task automatic pop_one();
        step(0, 0, 8'h00, 1);
    endtask

    task automatic do_reset();
        step(1, 0, 8'h00, 0);
        step(1, 0, 8'h00, 0);
    endtask

    bit [7:0] pool [12] = '{8'h12, 8'h59, 8'h58, 8'hF0, 8'hE0, 8'h1C,
                            8'h5A, 8'h4A, 8'h75, 8'hAA, 8'hFA, 8'h32};

    initial begin
        reset        = 1'b1;
        rx_done_tick = 1'b0;
        rx_data      = 8'h00;
        rd           = 1'b0;
        model_reset();
        do_reset();

        // Make then break of the same key, then drain.
        send(8'h1C); send(8'hF0); send(8'h1C);
        chk_eq("one_entry", 32'(kb_code), 32'h1C);
        pop_one();
        chk_eq("drained", 32'(kb_empty), 32'd1);

        // Shift snapshot on and off.
        send(8'h12); send(8'h1C); send(8'hF0); send(8'h12); send(8'h1C);
        chk_eq("shifted_head", 32'({kb_code, shift}), 32'({8'h1C, 1'b1}));
        pop_one(); pop_one();

        // Caps toggle with typematic repeats.
        send(8'h58); send(8'h58); send(8'h58); send(8'hF0); send(8'h58);
        chk_eq("caps_on", 32'(caps_led), 32'd1);
        send(8'h58); send(8'hF0); send(8'h58);
        chk_eq("caps_off", 32'(caps_led), 32'd0);

        // Extended codes: only the keypad-enter make is queued.
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
        send(8'hE0); send(8'h5A);
        chk_eq("ext_head", 32'(kb_code), 32'h5A);
        pop_one();

        // Overflow with five makes, then simultaneous push and pop while full.
        do_reset();
        send(8'h15); send(8'h1D); send(8'h24); send(8'h2D); send(8'h2C);
        chk_eq("ovf_set", 32'(overflow), 32'd1);
        step(0, 1, 8'h35, 1);
        chk_eq("order_after_pp", 32'(kb_code), 32'h1D);
        pop_one(); pop_one(); pop_one(); pop_one();
        chk_eq("ovf_sticky", 32'(overflow), 32'd1);

        // Reset while a break prefix is pending.
        send(8'hF0);
        do_reset();
        send(8'h1C);
        chk_eq("after_rst_prefix", 32'(kb_code), 32'h1C);
        pop_one();

        // Back-to-back random traffic with occasional reset.
        for (int i = 0; i < 3000; i++) begin
            bit [7:0] b;
            b = ($urandom_range(0, 5) == 0) ? 8'($urandom) : pool[$urandom_range(0, 11)];
            step($urandom_range(0, 299) == 0, $urandom_range(0, 9) < 6, b,
                 $urandom_range(0, 9) < 3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
